gate_sweep_checker: RTL and testbench

Hardware sweep-and-check stage for the two-input gate under test (inputs `i0`, `i1`, output `op`). On a start request it drives the four input combinations into the gate in fixed order, waits a programmable settle time, and samples `op` for each. It assembles the 4-entry truth table, classifies the gate function, and flags whether the result matches an expected table. It replaces the simulation-only stimulus/monitor loop with synthesizable logic, so the same gate check runs on the board.

---
 rtl/gate_sweep_checker.sv | 92 +++++++++
 tb/tb_gate_sweep_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps a 2-input gate through all four input vectors, samples its output,
// then classifies the resulting truth table and compares it against EXPECTED_TT.
module gate_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0] EXPECTED_TT = 4'b0110
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       op,
  output logic       i0,
  output logic       i1,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] func_code,
  output logic       match
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
  state_t r_state, w_next;
  logic [1:0] r_k;
  logic [1:0] w_k1;
  logic [7:0] r_cnt;
  logic       w_tick;
  logic       w_last;
  logic [3:0] w_tt;
  logic [2:0] w_code;
  assign w_k1   = r_k + 2'd1;
  assign w_tick = r_cnt == 8'd0;
  assign w_last = r_state == SETTLE && w_tick && r_k == 2'd3;
  // The final sample lands in truth on the same edge, so classify with op spliced in.
  assign w_tt   = {op, truth[2:0]};
  assign busy   = r_state == SETTLE;
  assign done   = r_state == DONE;
  always_comb begin
    w_code = 3'd0;
    case (w_tt)
      4'b1000: w_code = 3'd1;
      4'b1110: w_code = 3'd2;
      4'b0110: w_code = 3'd3;
      4'b0111: w_code = 3'd4;
      4'b0001: w_code = 3'd5;
      4'b1001: w_code = 3'd6;
      4'b0000, 4'b1111: w_code = 3'd7;
      default: w_code = 3'd0;
    endcase
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? SETTLE : IDLE) :
             r_state == SETTLE ? (w_last ? DONE : SETTLE) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k       <= 2'd0;
      r_cnt     <= 8'd0;
      i0        <= 1'b0;
      i1        <= 1'b0;
      truth     <= 4'd0;
      func_code <= 3'd0;
      match     <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_k       <= 2'd0;
      r_cnt     <= RELOAD;
      i0        <= 1'b0;
      i1        <= 1'b0;
      truth     <= 4'd0;
      func_code <= 3'd0;
      match     <= 1'b0;
    end else if (r_state == SETTLE) begin
      if (!w_tick) r_cnt <= r_cnt - 8'd1;
      else begin
        truth[r_k] <= op;
        if (r_k != 2'd3) begin
          r_k   <= w_k1;
          i0    <= w_k1[0];
          i1    <= w_k1[1];
          r_cnt <= RELOAD;
        end else begin
          i0        <= 1'b0;
          i1        <= 1'b0;
          func_code <= w_code;
          match     <= w_tt == EXPECTED_TT;
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed checks of the gate sweep on three instances
// (settle times 4, 1 and 2), each driven by a behavioral gate model.
module tb_gate_sweep_checker;
  localparam int AND_G = 0, OR_G = 1, XOR_G = 2, NAND_G = 3, ONE_G = 4, ARB_G = 5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s4 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  int m4 = AND_G, m1 = AND_G, m2 = AND_G;
  logic op4, op1, op2;
  logic a4, b4, busy4, done4, match4;
  logic a1, b1, busy1, done1, match1;
  logic a2, b2, busy2, done2, match2;
  logic [3:0] tt4, tt1, tt2;
  logic [2:0] fc4, fc1, fc2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  function automatic logic gate(input int m, input logic a, input logic b);
    case (m)
      AND_G:   return a & b;
      OR_G:    return a | b;
      XOR_G:   return a ^ b;
      NAND_G:  return ~(a & b);
      ONE_G:   return 1'b1;
      default: return a & ~b;
    endcase
  endfunction
  assign op4 = gate(m4, a4, b4);
  assign op1 = gate(m1, a1, b1);
  assign op2 = gate(m2, a2, b2);
  gate_sweep_checker #(.SETTLE_CYCLES(4)) d4 (.clk(clk), .reset_n(reset_n), .start(s4), .op(op4),
    .i0(a4), .i1(b4), .busy(busy4), .done(done4), .truth(tt4), .func_code(fc4), .match(match4));
  gate_sweep_checker #(.SETTLE_CYCLES(1)) d1 (.clk(clk), .reset_n(reset_n), .start(s1), .op(op1),
    .i0(a1), .i1(b1), .busy(busy1), .done(done1), .truth(tt1), .func_code(fc1), .match(match1));
  gate_sweep_checker #(.SETTLE_CYCLES(2)) d2 (.clk(clk), .reset_n(reset_n), .start(s2), .op(op2),
    .i0(a2), .i1(b2), .busy(busy2), .done(done2), .truth(tt2), .func_code(fc2), .match(match2));
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    chk("rst_vec", {b4, a4}, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_truth", tt4, 0);
    chk("rst_func", fc4, 0);
    chk("rst_match", match4, 0);
    reset_n = 1'b1;
    tick(1);
    // AND, settle 4: vectors step every 4 cycles, done after 16
    m4 = AND_G; s4 = 1'b1;
    tick(1); s4 = 1'b0;
    chk("and_busy0", busy4, 1);
    chk("and_v0", {b4, a4}, 2'b00);
    tick(4); chk("and_v1", {b4, a4}, 2'b01);
    tick(4); chk("and_v2", {b4, a4}, 2'b10);
    tick(4); chk("and_v3", {b4, a4}, 2'b11);
    tick(3); chk("and_nodone15", done4, 0);
    chk("and_busy15", busy4, 1);
    tick(1);
    chk("and_done", done4, 1);
    chk("and_busy_done", busy4, 0);
    chk("and_vec_done", {b4, a4}, 2'b00);
    chk("and_truth", tt4, 4'b1000);
    chk("and_func", fc4, 1);
    chk("and_match", match4, 0);
    tick(1); chk("and_done_pulse", done4, 0);
    // XOR with default expected table; results must hold while idle
    m4 = XOR_G; s4 = 1'b1;
    tick(1); s4 = 1'b0;
    tick(16);
    chk("xor_done", done4, 1);
    chk("xor_truth", tt4, 4'b0110);
    chk("xor_func", fc4, 3);
    chk("xor_match", match4, 1);
    tick(50);
    chk("xor_hold_truth", tt4, 4'b0110);
    chk("xor_hold_func", fc4, 3);
    chk("xor_hold_match", match4, 1);
    chk("xor_hold_busy", busy4, 0);
    // NAND, settle 1: done 4 cycles after acceptance
    m1 = NAND_G; s1 = 1'b1;
    tick(1); s1 = 1'b0;
    tick(3); chk("nand_nodone3", done1, 0);
    tick(1);
    chk("nand_done", done1, 1);
    chk("nand_truth", tt1, 4'b0111);
    chk("nand_func", fc1, 4);
    chk("nand_match", match1, 0);
    tick(1);
    m1 = ONE_G; s1 = 1'b1;
    tick(1); s1 = 1'b0;
    tick(4);
    chk("one_done", done1, 1);
    chk("one_truth", tt1, 4'b1111);
    chk("one_func", fc1, 7);
    // start held high, settle 2: period 10, busy low for 2 cycles
    m2 = AND_G; s2 = 1'b1;
    tick(1);
    tick(7); chk("held_nodone7", done2, 0);
    tick(1);
    chk("held_done8", done2, 1);
    chk("held_busy8", busy2, 0);
    tick(1);
    chk("held_done9", done2, 0);
    chk("held_busy9", busy2, 0);
    tick(1); chk("held_busy10", busy2, 1);
    tick(7); chk("held_nodone17", done2, 0);
    tick(1); chk("held_done18", done2, 1);
    chk("held_truth", tt2, 4'b1000);
    tick(2); chk("held_busy20", busy2, 1);
    s2 = 1'b0;
    tick(2); s2 = 1'b1;
    tick(1); s2 = 1'b0;
    tick(5); chk("mid_done28", done2, 1);
    tick(1); chk("mid_busy29", busy2, 0);
    tick(1);
    chk("mid_busy30", busy2, 0);
    chk("mid_done30", done2, 0);
    // async reset during vector 2 of an OR sweep
    m4 = OR_G; s4 = 1'b1;
    tick(1); s4 = 1'b0;
    tick(9);
    chk("pre_rst_i1", b4, 1);
    chk("pre_rst_truth", tt4, 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy4, 0);
    chk("arst_vec", {b4, a4}, 2'b00);
    chk("arst_truth", tt4, 0);
    chk("arst_func", fc4, 0);
    chk("arst_match", match4, 0);
    tick(2); reset_n = 1'b1;
    tick(3); chk("post_rst_idle", busy4, 0);
    s4 = 1'b1;
    tick(1); s4 = 1'b0;
    tick(16);
    chk("or_done", done4, 1);
    chk("or_truth", tt4, 4'b1110);
    chk("or_func", fc4, 2);
    chk("or_match", match4, 0);
    tick(1);
    // op = i0 & ~i1 is not a recognised function
    m4 = ARB_G; s4 = 1'b1;
    tick(1); s4 = 1'b0;
    tick(16);
    chk("arb_done", done4, 1);
    chk("arb_truth", tt4, 4'b0010);
    chk("arb_func", fc4, 0);
    chk("arb_match", match4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
